// File: rtl/rx_line_conditioner_if.sv
// ---------------------------------------------------------------------------
// rx_line_conditioner_if
// Signal bundle between the raw RX pin / deserializer side and the line
// conditioner.
//   rx_in      raw RS232 RX pin (idle high), driven towards the conditioner
//   baud_clk   re-phased baud clock, rising edge at bit centre
//   rx_out     retimed serial bit, stable across the baud_clk rising edge
//   busy       frame in progress (confirmed start bit .. stop bit sampled)
//   frame_err  one-clock pulse when a stop bit samples low
//   err_cnt    saturating framing-error count
// Modports:
//   master : the conditioner (drives everything except rx_in)
//   slave  : the pin / deserializer side
// ---------------------------------------------------------------------------
interface rx_line_conditioner_if;
   logic       rx_in;
   logic       baud_clk;
   logic       rx_out;
   logic       busy;
   logic       frame_err;
   logic [7:0] err_cnt;

   modport master (
      input  rx_in,
      output baud_clk,
      output rx_out,
      output busy,
      output frame_err,
      output err_cnt
   );

   modport slave (
      output rx_in,
      input  baud_clk,
      input  rx_out,
      input  busy,
      input  frame_err,
      input  err_cnt
   );
endinterface

// File: rtl/rx_line_conditioner.sv
// ---------------------------------------------------------------------------
// rx_line_conditioner
// Front end of the UART receive chain. Synchronises the raw RX pin, runs a
// 16x oversampling tick counter that is re-phased on each start bit, and
// produces a baud clock plus a retimed serial bit for the deserializer.
// Framing errors (stop bit low) are flagged and counted.
//
// Ports:
//   clk     system clock
//   reset   asynchronous, active-high reset
//   line    rx_line_conditioner_if.master
//             rx_in (in), baud_clk, rx_out, busy, frame_err, err_cnt[7:0] (out)
//
// Parameters:
//   CLK_HZ, BAUD  clock and line rate; DIV = (CLK_HZ + 8*BAUD) / (16*BAUD)
//   DATA_BITS     data bits per frame
//
// Configuration macro RX_LINE_MAJORITY_EN:
//   defined   -> bit value is the majority of samples at ticks 7, 8, 9
//   undefined -> bit value is the single sample at tick 8
// ---------------------------------------------------------------------------
module rx_line_conditioner #(
   parameter int CLK_HZ    = 50000000,
   parameter int BAUD      = 115200,
   parameter int DATA_BITS = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   rx_line_conditioner_if.master line
);

   localparam int DIV   = (CLK_HZ + 8 * BAUD) / (16 * BAUD);
   localparam int DIV_W = (DIV > 2) ? $clog2(DIV) : 1;
   localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
   // Sample point inside a tick; kept strictly before the last clock of the
   // tick so the tick-9 sample is registered before the end-of-tick-9 update.
   localparam logic [DIV_W-1:0] DIV_MID  = DIV_W'((DIV - 1) / 2);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

   generate
      if (DIV < 2) begin : g_div_check
         $error("rx_line_conditioner: DIV = %0d is below 2", DIV);
      end
      if (DATA_BITS < 1) begin : g_bits_check
         $error("rx_line_conditioner: DATA_BITS must be at least 1");
      end
   endgenerate

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP,
      S_BREAK
   } state_t;

   state_t           state_reg;
   logic             rx_meta_reg;
   logic             rx_s_reg;
   logic             rx_s_prev_reg;
   logic [DIV_W-1:0] div_reg;
   logic [3:0]       tick_reg;
   logic [IDX_W-1:0] idx_reg;
   logic             s8_reg;
   logic             baud_clk_reg;
   logic             rx_out_reg;
   logic             busy_reg;
   logic             frame_err_reg;
   logic [7:0]       err_cnt_reg;

   logic             fall_edge;
   logic             div_wrap;
   logic             bit_end;
   logic             bit_val;

`ifdef RX_LINE_MAJORITY_EN
   logic             s7_reg;
   logic             s9_reg;
   assign bit_val = (s7_reg & s8_reg) | (s7_reg & s9_reg) | (s8_reg & s9_reg);
`else
   assign bit_val = s8_reg;
`endif

   assign fall_edge = rx_s_prev_reg & ~rx_s_reg;
   assign div_wrap  = (div_reg == DIV_LAST);
   // End of tick 9: the single point where rx_out and the FSM advance.
   assign bit_end   = div_wrap && (tick_reg == 4'd9);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg     <= S_IDLE;
         rx_meta_reg   <= 1'b1;
         rx_s_reg      <= 1'b1;
         rx_s_prev_reg <= 1'b1;
         div_reg       <= '0;
         tick_reg      <= 4'd0;
         idx_reg       <= '0;
         s8_reg        <= 1'b1;
`ifdef RX_LINE_MAJORITY_EN
         s7_reg        <= 1'b1;
         s9_reg        <= 1'b1;
`endif
         baud_clk_reg  <= 1'b0;
         rx_out_reg    <= 1'b1;
         busy_reg      <= 1'b0;
         frame_err_reg <= 1'b0;
         err_cnt_reg   <= 8'd0;
      end else begin
         // Two-flop synchroniser; rx_s_prev only feeds the edge detector.
         rx_meta_reg   <= line.rx_in;
         rx_s_reg      <= rx_meta_reg;
         rx_s_prev_reg <= rx_s_reg;

         frame_err_reg <= 1'b0;

         if (div_wrap) begin
            div_reg  <= '0;
            tick_reg <= tick_reg + 4'd1;
         end else begin
            div_reg  <= div_reg + DIV_W'(1);
         end

         if (div_reg == DIV_MID) begin
            if (tick_reg == 4'd8) s8_reg <= rx_s_reg;
`ifdef RX_LINE_MAJORITY_EN
            if (tick_reg == 4'd7) s7_reg <= rx_s_reg;
            if (tick_reg == 4'd9) s9_reg <= rx_s_reg;
`endif
         end

         // Decoded from the registered tick, so the rising edge lands one
         // clock after the end-of-tick-9 rx_out update and the high phase
         // is exactly six ticks long.
         baud_clk_reg <= (tick_reg >= 4'd10);

         if (bit_end) begin
            rx_out_reg <= bit_val;
            unique case (state_reg)
               S_IDLE: ;
               S_START: begin
                  if (!bit_val) begin
                     busy_reg  <= 1'b1;
                     idx_reg   <= '0;
                     state_reg <= S_DATA;
                  end else begin
                     state_reg <= S_IDLE;
                  end
               end
               S_DATA: begin
                  if (idx_reg == IDX_LAST) state_reg <= S_STOP;
                  else                     idx_reg   <= idx_reg + IDX_W'(1);
               end
               S_STOP: begin
                  busy_reg <= 1'b0;
                  if (bit_val) begin
                     state_reg <= S_IDLE;
                  end else begin
                     frame_err_reg <= 1'b1;
                     if (err_cnt_reg != 8'hFF) err_cnt_reg <= err_cnt_reg + 8'd1;
                     state_reg <= S_BREAK;
                  end
               end
               S_BREAK: begin
                  if (bit_val) state_reg <= S_IDLE;
               end
               default: state_reg <= S_IDLE;
            endcase
         end

         // Start-bit re-phasing: overrides the counter and baud_clk updates
         // above. Forcing baud_clk low at once means the new bit timing
         // never extends a high phase that was already in progress.
         if ((state_reg == S_IDLE) && fall_edge) begin
            div_reg      <= '0;
            tick_reg     <= 4'd0;
            baud_clk_reg <= 1'b0;
            state_reg    <= S_START;
         end
      end
   end

   assign line.baud_clk  = baud_clk_reg;
   assign line.rx_out    = rx_out_reg;
   assign line.busy      = busy_reg;
   assign line.frame_err = frame_err_reg;
   assign line.err_cnt   = err_cnt_reg;

endmodule

// File: tb/tb_rx_line_conditioner.sv
// ---------------------------------------------------------------------------
// tb_rx_line_conditioner
// Directed bench for rx_line_conditioner. The main instance uses the default
// 50 MHz / 115200 configuration (DIV = 27, 432 clk per DUT bit). The line is
// driven at the true bit period of 434 clk. A second instance with DIV = 2
// and one data bit is used to reach framing-error counter saturation quickly.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_rx_line_conditioner;

   localparam int BIT_CLK = 434;   // 50e6 / 115200, line bit period
   localparam int DUT_BIT = 432;   // 16 * 27, DUT bit period
   localparam int HI_LEN  = 162;   // 6 * 27

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #10 clk = ~clk;

   rx_line_conditioner_if bus ();
   rx_line_conditioner_if bus2 ();

   rx_line_conditioner dut (
      .clk   (clk),
      .reset (reset),
      .line  (bus)
   );

   rx_line_conditioner #(
      .CLK_HZ    (115200 * 32),
      .BAUD      (115200),
      .DATA_BITS (1)
   ) dut_small (
      .clk   (clk),
      .reset (reset),
      .line  (bus2)
   );

   int checks = 0;
   int errors = 0;

   // Monitor state (written only by the monitor process).
   int   cyc = 0;
   int   hi_len = 0;
   int   last_hi = 0;
   int   last_period = 0;
   int   last_rise = 0;
   int   short_cnt = 0;
   int   busy_rise_cnt = 0;
   int   rxlow_cnt = 0;
   int   fe_cnt = 0;
   int   fe2_cnt = 0;
   int   cap_n = 0;
   logic cap_mem [1024];
   logic baud_prev = 1'b0;
   logic busy_prev = 1'b0;
   logic rise_valid = 1'b0;

   initial begin
      forever begin
         @(negedge clk);
         cyc++;
         if (bus2.frame_err) fe2_cnt++;
         if (reset) begin
            baud_prev  = 1'b0;
            busy_prev  = 1'b0;
            hi_len     = 0;
            rise_valid = 1'b0;
         end else begin
            if (bus.baud_clk) hi_len++;
            if (bus.baud_clk && !baud_prev) begin
               if (rise_valid) last_period = cyc - last_rise;
               last_rise  = cyc;
               rise_valid = 1'b1;
               if (bus.busy) begin
                  cap_mem[cap_n % 1024] = bus.rx_out;
                  cap_n++;
               end
            end
            if (!bus.baud_clk && baud_prev) begin
               last_hi = hi_len;
               if (hi_len < HI_LEN) short_cnt++;
               hi_len = 0;
            end
            if (bus.busy && !busy_prev) busy_rise_cnt++;
            if (!bus.rx_out) rxlow_cnt++;
            if (bus.frame_err) fe_cnt++;
            baud_prev = bus.baud_clk;
            busy_prev = bus.busy;
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic hold(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Full frame on the main instance. stop_low = 0 gives a normal high stop
   // bit; otherwise the line stays low for stop_low bit times after the data.
   // spike_bit >= 0 places a one-tick high spike at tick 8 of that data bit.
   task automatic send_frame(input logic [7:0] data, input int stop_low, input int spike_bit);
      int   nb;
      int   b;
      int   sp0;
      logic v;
      nb  = 9 + ((stop_low == 0) ? 1 : stop_low);
      sp0 = (spike_bit + 1) * DUT_BIT + 219;
      @(posedge clk);
      #1;
      for (int c = 0; c < nb * BIT_CLK; c++) begin
         b = c / BIT_CLK;
         if (b == 0)      v = 1'b0;
         else if (b <= 8) v = data[b-1];
         else             v = (stop_low == 0);
         if (spike_bit >= 0 && c >= sp0 && c < sp0 + 27) v = 1'b1;
         bus.rx_in = v;
         @(posedge clk);
         #1;
      end
      bus.rx_in = 1'b1;
   endtask

   function automatic logic [7:0] cap_byte(input int base);
      logic [7:0] r;
      for (int i = 0; i < 8; i++) r[i] = cap_mem[(base + 1 + i) % 1024];
      return r;
   endfunction

   task automatic wait_baud_fall(output logic timed_out);
      logic prev;
      int   n;
      prev = bus.baud_clk;
      n = 0;
      timed_out = 1'b1;
      while (n < 1000) begin
         @(posedge clk);
         #1;
         if (prev && !bus.baud_clk) begin
            timed_out = 1'b0;
            break;
         end
         prev = bus.baud_clk;
         n++;
      end
   endtask

   initial begin
      int         base;
      int         fe0;
      int         br0;
      int         sc0;
      int         rl0;
      int         fe2_0;
      logic       to;
      logic [7:0] b5a;
      logic [7:0] spike_exp;

      bus.rx_in  = 1'b1;
      bus2.rx_in = 1'b1;
      b5a = 8'h5A;

      // Reset state
      hold(3);
      check("rst_baud_clk", {31'd0, bus.baud_clk}, 32'd0);
      check("rst_rx_out", {31'd0, bus.rx_out}, 32'd1);
      check("rst_busy", {31'd0, bus.busy}, 32'd0);
      check("rst_frame_err", {31'd0, bus.frame_err}, 32'd0);
      check("rst_err_cnt", {24'd0, bus.err_cnt}, 32'd0);
      reset = 1'b0;
      $display("step reset: released");

      // 1. Idle line: free-running baud clock
      hold(1500);
      check("idle_period", last_period, 32'd432);
      check("idle_high", last_hi, HI_LEN);
      check("idle_rx_out", {31'd0, bus.rx_out}, 32'd1);
      check("idle_busy", {31'd0, bus.busy}, 32'd0);
      $display("step idle: period %0d high %0d", last_period, last_hi);

      // 2. Byte 0x35
      base = cap_n;
      fe0  = fe_cnt;
      send_frame(8'h35, 0, -1);
      hold(400);
      check("b35_edges", cap_n - base, 32'd9);
      check("b35_start_bit", {31'd0, cap_mem[base % 1024]}, 32'd0);
      check("b35_byte", {24'd0, cap_byte(base)}, 32'h35);
      check("b35_busy_after", {31'd0, bus.busy}, 32'd0);
      check("b35_frame_err", fe_cnt - fe0, 32'd0);
      $display("step byte35: got %02h", cap_byte(base));

      // 3. 1 us glitch while baud_clk is low
      wait_baud_fall(to);
      check("glitch_sync_timeout", {31'd0, to}, 32'd0);
      sc0 = short_cnt;
      br0 = busy_rise_cnt;
      rl0 = rxlow_cnt;
      bus.rx_in = 1'b0;
      hold(50);
      bus.rx_in = 1'b1;
      hold(1000);
      check("glitch_short_pulse", short_cnt - sc0, 32'd0);
      check("glitch_busy", busy_rise_cnt - br0, 32'd0);
      check("glitch_rx_out", rxlow_cnt - rl0, 32'd0);
      check("glitch_high_len", last_hi, HI_LEN);
      $display("step glitch: short %0d busy_rises %0d", short_cnt - sc0, busy_rise_cnt - br0);

      // 4. 0x00 with stop low for 3 bit times, then 0xA5
      base = cap_n;
      fe0  = fe_cnt;
      br0  = busy_rise_cnt;
      send_frame(8'h00, 3, -1);
      hold(600);
      check("brk_frame_err", fe_cnt - fe0, 32'd1);
      check("brk_err_cnt", {24'd0, bus.err_cnt}, 32'd1);
      check("brk_busy_rises", busy_rise_cnt - br0, 32'd1);
      check("brk_byte", {24'd0, cap_byte(base)}, 32'h00);
      base = cap_n;
      send_frame(8'hA5, 0, -1);
      hold(400);
      check("a5_edges", cap_n - base, 32'd9);
      check("a5_byte", {24'd0, cap_byte(base)}, 32'hA5);
      $display("step break: err_cnt %0d next byte %02h", bus.err_cnt, cap_byte(base));

      // 5. Reset during data bit 4 of 0x5A
      @(posedge clk);
      #1;
      bus.rx_in = 1'b0;
      hold(BIT_CLK);
      for (int i = 0; i < 4; i++) begin
         bus.rx_in = b5a[i];
         hold(BIT_CLK);
      end
      bus.rx_in = b5a[4];
      hold(200);
      check("mid_busy", {31'd0, bus.busy}, 32'd1);
      @(posedge clk);
      #5;
      reset = 1'b1;
      #1;
      check("arst_baud_clk", {31'd0, bus.baud_clk}, 32'd0);
      check("arst_rx_out", {31'd0, bus.rx_out}, 32'd1);
      check("arst_busy", {31'd0, bus.busy}, 32'd0);
      check("arst_err_cnt", {24'd0, bus.err_cnt}, 32'd0);
      check("arst_frame_err", {31'd0, bus.frame_err}, 32'd0);
      bus.rx_in = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      hold(1000);
      base = cap_n;
      send_frame(8'h5A, 0, -1);
      hold(400);
      check("r5a_edges", cap_n - base, 32'd9);
      check("r5a_byte", {24'd0, cap_byte(base)}, 32'h5A);
      $display("step reset_mid: got %02h", cap_byte(base));

      // 6a. One-tick spike at tick 8 of data bit 1 of 0x00
`ifdef RX_LINE_MAJORITY_EN
      spike_exp = 8'h00;
`else
      spike_exp = 8'h02;
`endif
      base = cap_n;
      send_frame(8'h00, 0, 1);
      hold(400);
      check("spike_edges", cap_n - base, 32'd9);
      check("spike_byte", {24'd0, cap_byte(base)}, {24'd0, spike_exp});
      $display("step spike: got %02h", cap_byte(base));

      // 6b. 300 framing errors on the small instance
      fe2_0 = fe2_cnt;
      for (int k = 0; k < 300; k++) begin
         bus2.rx_in = 1'b0;
         hold(96);
         bus2.rx_in = 1'b1;
         hold(32);
         if (k == 253) check("sat_254", {24'd0, bus2.err_cnt}, 32'd254);
      end
      hold(200);
      check("sat_err_cnt", {24'd0, bus2.err_cnt}, 32'd255);
      check("sat_pulses", fe2_cnt - fe2_0, 32'd300);
      check("sat_busy", {31'd0, bus2.busy}, 32'd0);
      check("sat_rx_out", {31'd0, bus2.rx_out}, 32'd1);
      $display("step saturate: err_cnt %0d pulses %0d", bus2.err_cnt, fe2_cnt - fe2_0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
